// File: rtl/cache_l1_arbiter.sv
// -----------------------------------------------------------------------------
// cache_l1_arbiter
//
// Purpose:
//   Arbitrates between the I-cache and D-cache miss ports and issues one
//   request at a time into the L1->L2 level-split register. Ties are broken
//   round-robin using the side granted most recently. When L2 completes a
//   request, the winner gets a one-cycle *_resp strobe. In the same cycle the
//   split register is reloaded with an all-zero request, so L2 never sees a
//   stale request.
//
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   icache_address/read         I-cache line read request (held until resp)
//   icache_rdata/resp           line returned to I-cache, completion strobe
//   dcache_address/wdata        D-cache miss/writeback address and line
//   dcache_read/write           D-cache request flags (held until resp)
//   dcache_rdata/resp           line returned to D-cache, completion strobe
//   l2_load/address/wdata/
//   l2_read/write               request into the level-split register
//   l2_resp/rdata               L2 completion strobe and read line
// -----------------------------------------------------------------------------
module cache_l1_arbiter (
  input  logic         clk,
  input  logic         reset,

  input  logic [15:0]  icache_address,
  input  logic         icache_read,
  output logic [127:0] icache_rdata,
  output logic         icache_resp,

  input  logic [15:0]  dcache_address,
  input  logic [127:0] dcache_wdata,
  input  logic         dcache_read,
  input  logic         dcache_write,
  output logic [127:0] dcache_rdata,
  output logic         dcache_resp,

  output logic         l2_load,
  output logic [15:0]  l2_address,
  output logic [127:0] l2_wdata,
  output logic         l2_read,
  output logic         l2_write,
  input  logic         l2_resp,
  input  logic [127:0] l2_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  state_e state_q, state_d;
  grant_e last_grant_q, last_grant_d;

  logic i_req;
  logic d_req;
  logic grant_d;

  // Read data is broadcast to both caches. Only the resp strobe is steered.
  assign icache_rdata = l2_rdata;
  assign dcache_rdata = l2_rdata;

  assign i_req = icache_read;
  assign d_req = dcache_read | dcache_write;

  // D wins when it requests alone, or on a tie when I was served last.
  assign grant_d = d_req & (~i_req | (last_grant_q == GRANT_I));

  // NOTE: every output and next-state signal gets a default before any branch,
  // so no path through this block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    icache_resp  = 1'b0;
    dcache_resp  = 1'b0;
    l2_load      = 1'b0;
    l2_address   = '0;
    l2_wdata     = '0;
    l2_read      = 1'b0;
    l2_write     = 1'b0;

    if (reset) begin
      // Load zeros into the split register for as long as reset is held.
      l2_load = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (grant_d) begin
            l2_load      = 1'b1;
            l2_address   = dcache_address;
            l2_wdata     = dcache_wdata;
            // A write takes priority if both flags are raised together.
            l2_write     = dcache_write;
            l2_read      = dcache_read & ~dcache_write;
            last_grant_d = GRANT_D;
            state_d      = ST_BUSY_D;
          end else if (i_req) begin
            l2_load      = 1'b1;
            l2_address   = icache_address;
            l2_read      = 1'b1;
            last_grant_d = GRANT_I;
            state_d      = ST_BUSY_I;
          end
        end

        ST_BUSY_I: begin
          if (l2_resp) begin
            icache_resp = 1'b1;
            l2_load     = 1'b1;   // load the zero request to flush the register
            state_d     = ST_IDLE;
          end
        end

        ST_BUSY_D: begin
          if (l2_resp) begin
            dcache_resp = 1'b1;
            l2_load     = 1'b1;
            state_d     = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments, so every register
  // samples values from before the clock edge, regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_cache_l1_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_l1_arbiter
//
// Directed bench for cache_l1_arbiter. Inputs change 1 time unit after each
// rising edge. Outputs are compared one unit later, well away from the edge.
// -----------------------------------------------------------------------------
module tb_cache_l1_arbiter;

  logic         clk;
  logic         reset;
  logic [15:0]  icache_address;
  logic         icache_read;
  logic [127:0] icache_rdata;
  logic         icache_resp;
  logic [15:0]  dcache_address;
  logic [127:0] dcache_wdata;
  logic         dcache_read;
  logic         dcache_write;
  logic [127:0] dcache_rdata;
  logic         dcache_resp;
  logic         l2_load;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic         l2_read;
  logic         l2_write;
  logic         l2_resp;
  logic [127:0] l2_rdata;

  int total;
  int bad;

  localparam logic [127:0] RDATA_A = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [127:0] RDATA_B = 128'h0F0F_F0F0_A5A5_5A5A_C3C3_3C3C_9696_6969;
  localparam logic [127:0] WDATA_A = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

  cache_l1_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .icache_address (icache_address),
    .icache_read    (icache_read),
    .icache_rdata   (icache_rdata),
    .icache_resp    (icache_resp),
    .dcache_address (dcache_address),
    .dcache_wdata   (dcache_wdata),
    .dcache_read    (dcache_read),
    .dcache_write   (dcache_write),
    .dcache_rdata   (dcache_rdata),
    .dcache_resp    (dcache_resp),
    .l2_load        (l2_load),
    .l2_address     (l2_address),
    .l2_wdata       (l2_wdata),
    .l2_read        (l2_read),
    .l2_write       (l2_write),
    .l2_resp        (l2_resp),
    .l2_rdata       (l2_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let the combinational outputs settle after new inputs are driven.
  task automatic settle();
    #1;
  endtask

  // The split-register request fields, checked together.
  task automatic check_l2(input string tag, input logic load, input logic [15:0] addr,
                          input logic [127:0] wd, input logic rd, input logic wr);
    check({tag, ".load"},  {127'd0, l2_load},  {127'd0, load});
    check({tag, ".addr"},  {112'd0, l2_address}, {112'd0, addr});
    check({tag, ".wdata"}, l2_wdata, wd);
    check({tag, ".read"},  {127'd0, l2_read},  {127'd0, rd});
    check({tag, ".write"}, {127'd0, l2_write}, {127'd0, wr});
  endtask

  task automatic check_resp(input string tag, input logic ir, input logic dr);
    check({tag, ".iresp"}, {127'd0, icache_resp}, {127'd0, ir});
    check({tag, ".dresp"}, {127'd0, dcache_resp}, {127'd0, dr});
  endtask

  initial begin
    total = 0;
    bad   = 0;

    reset          = 1'b1;
    icache_address = 16'h0000;
    icache_read    = 1'b0;
    dcache_address = 16'h0000;
    dcache_wdata   = '0;
    dcache_read    = 1'b0;
    dcache_write   = 1'b0;
    l2_resp        = 1'b0;
    l2_rdata       = RDATA_B;

    // ---- Reset state ------------------------------------------------------
    tick();
    settle();
    check_l2("rst", 1'b1, 16'h0000, '0, 1'b0, 1'b0);
    check_resp("rst", 1'b0, 1'b0);
    check("rst.irdata", icache_rdata, RDATA_B);
    check("rst.drdata", dcache_rdata, RDATA_B);

    // ---- I-cache read alone ----------------------------------------------
    tick();
    reset          = 1'b0;
    icache_read    = 1'b1;
    icache_address = 16'h1230;
    settle();
    check_l2("i_c0", 1'b1, 16'h1230, '0, 1'b1, 1'b0);
    check_resp("i_c0", 1'b0, 1'b0);

    tick();  // cycle 1: busy, the request is no longer driven
    settle();
    check_l2("i_c1", 1'b0, 16'h0000, '0, 1'b0, 1'b0);
    tick();  // cycle 2
    tick();  // cycle 3
    settle();
    check_l2("i_c3", 1'b0, 16'h0000, '0, 1'b0, 1'b0);
    check_resp("i_c3", 1'b0, 1'b0);

    tick();  // cycle 4: L2 answers
    l2_resp  = 1'b1;
    l2_rdata = RDATA_A;
    settle();
    check_resp("i_c4", 1'b1, 1'b0);
    check("i_c4.irdata", icache_rdata, RDATA_A);
    check_l2("i_c4", 1'b1, 16'h0000, '0, 1'b0, 1'b0);

    tick();  // cycle 5: idle, requester has dropped
    l2_resp     = 1'b0;
    icache_read = 1'b0;
    settle();
    check_l2("i_c5", 1'b0, 16'h0000, '0, 1'b0, 1'b0);
    check_resp("i_c5", 1'b0, 1'b0);

    // ---- D-cache write alone ---------------------------------------------
    dcache_address = 16'h4440;
    dcache_wdata   = WDATA_A;
    dcache_write   = 1'b1;
    settle();
    check_l2("dw_g", 1'b1, 16'h4440, WDATA_A, 1'b0, 1'b1);

    tick();
    settle();
    check_l2("dw_busy", 1'b0, 16'h0000, '0, 1'b0, 1'b0);
    tick();
    l2_resp = 1'b1;
    settle();
    check_resp("dw_r", 1'b0, 1'b1);
    check_l2("dw_r", 1'b1, 16'h0000, '0, 1'b0, 1'b0);
    tick();
    l2_resp      = 1'b0;
    dcache_write = 1'b0;
    dcache_wdata = '0;
    settle();
    check_l2("dw_idle", 1'b0, 16'h0000, '0, 1'b0, 1'b0);

    // ---- Reset puts last_grant back to I (it is D here) -------------------
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // ---- Sustained contention: D, I, D, I ---------------------------------
    icache_address = 16'h1230;
    icache_read    = 1'b1;
    dcache_address = 16'h5550;
    dcache_read    = 1'b1;
    settle();
    check_l2("cont1_g", 1'b1, 16'h5550, '0, 1'b1, 1'b0);
    tick();
    l2_resp = 1'b1;
    settle();
    check_resp("cont1_r", 1'b0, 1'b1);

    tick();  // I granted in the cycle after D's l2_resp
    l2_resp = 1'b0;
    settle();
    check_l2("cont2_g", 1'b1, 16'h1230, '0, 1'b1, 1'b0);
    tick();
    l2_resp = 1'b1;
    settle();
    check_resp("cont2_r", 1'b1, 1'b0);

    tick();
    l2_resp = 1'b0;
    settle();
    check_l2("cont3_g", 1'b1, 16'h5550, '0, 1'b1, 1'b0);
    tick();
    tick();  // one extra busy cycle
    l2_resp = 1'b1;
    settle();
    check_resp("cont3_r", 1'b0, 1'b1);

    tick();
    l2_resp = 1'b0;
    settle();
    check_l2("cont4_g", 1'b1, 16'h1230, '0, 1'b1, 1'b0);
    tick();
    l2_resp = 1'b1;
    settle();
    check_resp("cont4_r", 1'b1, 1'b0);
    tick();
    l2_resp     = 1'b0;
    icache_read = 1'b0;
    dcache_read = 1'b0;
    settle();
    check_l2("cont_idle", 1'b0, 16'h0000, '0, 1'b0, 1'b0);

    // ---- Reset in BUSY_D before l2_resp -----------------------------------
    dcache_read = 1'b1;
    settle();
    check_l2("rb_g", 1'b1, 16'h5550, '0, 1'b1, 1'b0);
    tick();
    reset = 1'b1;
    settle();
    check_l2("rb_rst0", 1'b1, 16'h0000, '0, 1'b0, 1'b0);
    check_resp("rb_rst0", 1'b0, 1'b0);
    tick();
    l2_resp = 1'b1;  // must not complete anything while reset is held
    settle();
    check_l2("rb_rst1", 1'b1, 16'h0000, '0, 1'b0, 1'b0);
    check_resp("rb_rst1", 1'b0, 1'b0);
    tick();
    reset       = 1'b0;
    l2_resp     = 1'b0;
    icache_read = 1'b1;
    settle();
    // last_grant was D before reset, so a D win proves it was cleared to I.
    check_l2("rb_tie", 1'b1, 16'h5550, '0, 1'b1, 1'b0);
    tick();
    l2_resp = 1'b1;
    settle();
    check_resp("rb_done", 1'b0, 1'b1);
    tick();
    l2_resp = 1'b0;
    settle();
    check_l2("rb_i", 1'b1, 16'h1230, '0, 1'b1, 1'b0);
    tick();
    l2_resp = 1'b1;
    settle();
    check_resp("rb_i_r", 1'b1, 1'b0);
    tick();
    l2_resp     = 1'b0;
    icache_read = 1'b0;
    dcache_read = 1'b0;

    // ---- Stray l2_resp in IDLE --------------------------------------------
    l2_resp = 1'b1;
    settle();
    check_resp("stray", 1'b0, 1'b0);
    check_l2("stray", 1'b0, 16'h0000, '0, 1'b0, 1'b0);
    tick();
    l2_resp = 1'b0;
    // Still IDLE: a new request is granted immediately.
    dcache_address = 16'h7770;
    dcache_wdata   = WDATA_A;
    dcache_read    = 1'b1;
    dcache_write   = 1'b1;
    settle();
    check_l2("rw_g", 1'b1, 16'h7770, WDATA_A, 1'b0, 1'b1);
    tick();
    l2_resp = 1'b1;
    settle();
    check_resp("rw_r", 1'b0, 1'b1);
    tick();
    l2_resp      = 1'b0;
    dcache_read  = 1'b0;
    dcache_write = 1'b0;
    settle();
    check_l2("final_idle", 1'b0, 16'h0000, '0, 1'b0, 1'b0);
    check_resp("final_idle", 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
